// File: rtl/pop_arbiter_nvc.sv
// Pop arbiter for NUM_VC virtual-channel FIFOs: strict priority or weighted round-robin.
// Optional per-VC saturating pop counters when POP_ARB_STATS_EN is defined.
module pop_arbiter_nvc #(
  parameter int NUM_VC   = 4,
  parameter int NUM_DEST = 2,
  parameter int WEIGHT_W = 4,
  parameter int SEL_W    = $clog2(NUM_VC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_VC-1:0]          vc_empty,
  input  logic [NUM_DEST-1:0]        dest_full,
  input  logic                       mode_wrr,
  input  logic [NUM_VC*WEIGHT_W-1:0] weights,
`ifdef POP_ARB_STATS_EN
  input  logic                       clr_stats,
  output logic [NUM_VC*16-1:0]       pop_count,
`endif
  output logic [NUM_VC-1:0]          vc_rd,
  output logic [SEL_W-1:0]           sel_q,
  output logic                       valid_q,
  output logic                       stall
);

  logic [SEL_W-1:0]    ptr;
  logic [WEIGHT_W-1:0] credit;

  logic                grant;
  logic [SEL_W-1:0]    g;
  logic                eligible;
  logic                any_ready;
  logic                found;
  logic [SEL_W-1:0]    srch;
  logic [SEL_W-1:0]    lo;
  logic [WEIGHT_W-1:0] wload;
  int                  p;

  always_comb begin
    stall     = |dest_full;
    any_ready = ~&vc_empty;
    eligible  = !vc_empty[ptr] && (credit != '0);
    found     = 1'b0;
    srch      = ptr;
    lo        = '0;
    p         = 0;
    // ptr itself is searched last (i == NUM_VC wraps back to it)
    for (int i = 1; i <= NUM_VC; i++) begin
      p = int'(ptr) + i;
      if (p >= NUM_VC) p = p - NUM_VC;
      if (!found && !vc_empty[p]) begin
        found = 1'b1;
        srch  = SEL_W'(p);
      end
    end
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (!vc_empty[i]) lo = SEL_W'(i);
    end
    wload = weights[int'(srch)*WEIGHT_W +: WEIGHT_W];
    if (wload == '0) wload = WEIGHT_W'(1);
    grant = 1'b0;
    g     = '0;
    if (reset || stall || !any_ready) begin
      grant = 1'b0;
    end else if (!mode_wrr) begin
      grant = 1'b1;
      g     = lo;
    end else if (eligible) begin
      grant = 1'b1;
      g     = ptr;
    end else begin
      grant = 1'b1;
      g     = srch;
    end
    vc_rd = grant ? (NUM_VC'(1) << g) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      credit  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= grant;
      if (grant) begin
        sel_q <= g;
        if (!mode_wrr) begin
          credit <= '0;
        end else if (eligible) begin
          credit <= credit - WEIGHT_W'(1);
        end else begin
          ptr    <= srch;
          credit <= wload - WEIGHT_W'(1);
        end
      end
    end
  end

`ifdef POP_ARB_STATS_EN
  logic [15:0] cnt [NUM_VC];

  for (genvar i = 0; i < NUM_VC; i++) begin : g_stats
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if (clr_stats) begin
        cnt[i] <= '0;
      end else if (vc_rd[i] && cnt[i] != 16'hFFFF) begin
        cnt[i] <= cnt[i] + 16'd1;
      end
    end
    assign pop_count[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_pop_arbiter_nvc.sv
// Self-checking bench for pop_arbiter_nvc (NUM_VC=4, NUM_DEST=2, WEIGHT_W=4).
// Table vectors for strict mode plus hand sequences for WRR, stall, forfeit, reset.
module tb_pop_arbiter_nvc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  vc_empty;
  logic [1:0]  dest_full;
  logic        mode_wrr;
  logic [15:0] weights;
  logic [3:0]  vc_rd;
  logic [1:0]  sel_q;
  logic        valid_q;
  logic        stall;
`ifdef POP_ARB_STATS_EN
  logic        clr_stats;
  logic [63:0] pop_count;
`endif

  pop_arbiter_nvc #(
    .NUM_VC(4), .NUM_DEST(2), .WEIGHT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vc_empty(vc_empty),
    .dest_full(dest_full),
    .mode_wrr(mode_wrr),
    .weights(weights),
`ifdef POP_ARB_STATS_EN
    .clr_stats(clr_stats),
    .pop_count(pop_count),
`endif
    .vc_rd(vc_rd),
    .sel_q(sel_q),
    .valid_q(valid_q),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [1:0] sel;
  } exp_t;

  typedef struct packed {
    logic [3:0] e;
    logic [1:0] f;
    logic [3:0] rd;
  } vec_t;

  exp_t       sb[$];
  logic [1:0] last_sel;
  int         checks;
  int         failures;
  int         act_cnt [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic [3:0] e, input logic [1:0] f,
                      input logic [3:0] exp_rd, input string nm);
    exp_t x;
    exp_t y;
    vc_empty  = e;
    dest_full = f;
    #2;
    chk({nm, " vc_rd"}, 32'(vc_rd), 32'(exp_rd));
    chk({nm, " stall"}, 32'(stall), 32'(|f));
    for (int i = 0; i < 4; i++) act_cnt[i] += int'(vc_rd[i]);
    x.valid = (exp_rd != 4'd0);
    if (x.valid) last_sel = idx(exp_rd);
    x.sel = last_sel;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: got empty expected entry", nm);
    end else begin
      y = sb.pop_front();
      chk({nm, " valid_q"}, 32'(valid_q), 32'(y.valid));
      chk({nm, " sel_q"}, 32'(sel_q), 32'(y.sel));
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    vc_empty  = 4'b0000;
    dest_full = 2'b00;
    last_sel  = 2'd0;
    for (int i = 0; i < 4; i++) act_cnt[i] = 0;
    @(posedge clk);
    #1;
    chk("rst vc_rd", 32'(vc_rd), 32'd0);
    chk("rst sel_q", 32'(sel_q), 32'd0);
    chk("rst valid_q", 32'(valid_q), 32'd0);
    reset = 1'b0;
  endtask

  vec_t tbl [10];
  int   pat [7];

  initial begin
    checks   = 0;
    failures = 0;
    mode_wrr = 1'b0;
    weights  = 16'h1111;
`ifdef POP_ARB_STATS_EN
    clr_stats = 1'b0;
`endif
    tbl[0] = '{e: 4'b0000, f: 2'b00, rd: 4'b0001};
    tbl[1] = '{e: 4'b0000, f: 2'b00, rd: 4'b0001};
    tbl[2] = '{e: 4'b0001, f: 2'b00, rd: 4'b0010};
    tbl[3] = '{e: 4'b0011, f: 2'b00, rd: 4'b0100};
    tbl[4] = '{e: 4'b0111, f: 2'b00, rd: 4'b1000};
    tbl[5] = '{e: 4'b1111, f: 2'b00, rd: 4'b0000};
    tbl[6] = '{e: 4'b0000, f: 2'b10, rd: 4'b0000};
    tbl[7] = '{e: 4'b1010, f: 2'b00, rd: 4'b0001};
    tbl[8] = '{e: 4'b0000, f: 2'b01, rd: 4'b0000};
    tbl[9] = '{e: 4'b0101, f: 2'b00, rd: 4'b0010};

    // strict priority table
    do_reset();
    for (int i = 0; i < 10; i++) step(tbl[i].e, tbl[i].f, tbl[i].rd, "strict");

    // WRR ratio: VC0=3, VC1=2, VC2=1, VC3=1
    mode_wrr = 1'b1;
    weights  = {4'd1, 4'd1, 4'd2, 4'd3};
    do_reset();
    pat = '{1, 1, 2, 3, 0, 0, 0};
    for (int c = 0; c < 28; c++) step(4'b0000, 2'b00, 4'(1 << pat[c % 7]), "wrr");
    chk("wrr cnt0", 32'(act_cnt[0]), 32'd12);
    chk("wrr cnt1", 32'(act_cnt[1]), 32'd8);
    chk("wrr cnt2", 32'(act_cnt[2]), 32'd4);
    chk("wrr cnt3", 32'(act_cnt[3]), 32'd4);

    // back-pressure mid-burst, VC1 weight 3 leaves credit 2
    weights = {4'd1, 4'd1, 4'd3, 4'd1};
    do_reset();
    step(4'b0000, 2'b00, 4'b0010, "bp first");
    for (int i = 0; i < 3; i++) step(4'b0000, 2'b10, 4'b0000, "bp stall");
    step(4'b0000, 2'b00, 4'b0010, "bp resume1");
    step(4'b0000, 2'b00, 4'b0010, "bp resume2");
    step(4'b0000, 2'b00, 4'b0100, "bp next");

    // empty VC forfeits credit, VC1 weight 5
    weights = {4'd1, 4'd1, 4'd5, 4'd1};
    do_reset();
    step(4'b0000, 2'b00, 4'b0010, "ff vc1");
    step(4'b0010, 2'b00, 4'b0100, "ff vc2");
    step(4'b0000, 2'b00, 4'b1000, "ff vc3");
    step(4'b0000, 2'b00, 4'b0001, "ff vc0");
    for (int i = 0; i < 5; i++) step(4'b0000, 2'b00, 4'b0010, "ff reload");
    step(4'b0000, 2'b00, 4'b0100, "ff after");

    // asynchronous reset between edges
    mode_wrr = 1'b0;
    weights  = 16'h1111;
    do_reset();
    step(4'b0011, 2'b00, 4'b0100, "ar pre");
    #2;
    chk("ar live vc_rd", 32'(vc_rd), 32'b0100);
    reset = 1'b1;
    #1;
    chk("ar vc_rd", 32'(vc_rd), 32'd0);
    chk("ar sel_q", 32'(sel_q), 32'd0);
    chk("ar valid_q", 32'(valid_q), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    last_sel = 2'd0;
    mode_wrr = 1'b1;
    step(4'b0000, 2'b00, 4'b0010, "ar first");

`ifdef POP_ARB_STATS_EN
    mode_wrr = 1'b0;
    do_reset();
    vc_empty  = 4'b0000;
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("stats preload", 32'(pop_count[15:0]), 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("stats sat", 32'(pop_count[15:0]), 32'hFFFF);
    chk("stats vc1", 32'(pop_count[31:16]), 32'd0);
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    chk("stats clr", 32'(pop_count[15:0]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
